// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, words-per-state count and the
// GF(2^8) doubling helper used by the column unit.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_WORDS = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mixw.sv
// Combinational inverse-MixColumns of one 32-bit column; byte 0 is [31:24].
module aes_inv_mixw
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x4  [4];
  logic [7:0] x8  [4];
  logic [7:0] m9  [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];

  // Multiples 9, 11, 13 and 14 built from a chain of doublings.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign mixed = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                  m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                  m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                  m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};

endmodule

// File: rtl/aes_inv_mixcol_ctrl.sv
// Word-serial InvMixColumns over a 128-bit AES state with one shared column unit.
// Define AES_INV_MIXCOL_LAST_SKIP_EN to pass last-round states straight to DONE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid_o/data_o hold steady until taken, ready_o only in IDLE.
module aes_inv_mixcol_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
  input  logic         last_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  state_t       state_q, state_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic [1:0]   cnt_q;
  logic [127:0] data_q;
  logic [31:0]  col_in, col_out;
  logic         accept;

  assign accept = valid_i & ready_q;

`ifndef AES_INV_MIXCOL_LAST_SKIP_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef AES_INV_MIXCOL_LAST_SKIP_EN
          state_d = last_i ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY:    if (cnt_q == 2'(NUM_WORDS - 1)) state_d = DONE;
      DONE:    if (valid_q & ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the state being entered.
  always_comb begin
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_comb begin
    case (cnt_q)
      2'd0:    col_in = data_q[127:96];
      2'd1:    col_in = data_q[95:64];
      2'd2:    col_in = data_q[63:32];
      default: col_in = data_q[31:0];
    endcase
  end

  aes_inv_mixw u_mixw (
    .col   (col_in),
    .mixed (col_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      data_q <= data_i;
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      case (cnt_q)
        2'd0:    data_q[127:96] <= col_out;
        2'd1:    data_q[95:64]  <= col_out;
        2'd2:    data_q[63:32]  <= col_out;
        default: data_q[31:0]   <= col_out;
      endcase
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_aes_inv_mixcol_ctrl.sv
// Self-checking bench for aes_inv_mixcol_ctrl against a matrix-level InvMixColumns model.
module tb_aes_inv_mixcol_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [127:0] data_i = '0;
  logic         last_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [127:0] data_o;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];

  aes_inv_mixcol_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;

`ifdef AES_INV_MIXCOL_LAST_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ p;
      p = (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_state(input logic [127:0] s);
    int m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127 - 32*c - 8*k -: 8], m[row][k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] expected(input logic [127:0] d, input logic last);
    return (SKIP && last) ? d : inv_mix_state(d);
  endfunction

  // ---------------- driver helpers ----------------
  task automatic accept_one(input logic [127:0] d, input logic last, output bit ok);
    ok = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = last;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic handshake_out();
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || data_o !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready_o=%b valid_o=%b data_o=%h required 0/0/0", ready_o, valid_o, data_o);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_known_vector(input logic [127:0] d, input logic [127:0] exp, input string name);
    bit ok;
    int cyc;
    accept_one(d, 1'b0, ok);
    wait_valid(cyc);
    tests++;
    if (!ok || cyc !== 4) begin
      fails++;
      $display("FAIL %s_latency: accepted=%0d cycles=%0d required 4", name, ok, cyc);
    end
    tests++;
    if (data_o !== exp) begin
      fails++;
      $display("FAIL %s_data: got %h required %h", name, data_o, exp);
    end
    handshake_out();
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    bit bad = 1'b0;
    logic [127:0] exp = 128'hc6c6c6c6_2d26314c_00000000_ffffffff;
    accept_one(128'hc6c6c6c6_4d7ebdf8_00000000_ffffffff, 1'b0, ok);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== exp) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok || bad || data_o !== exp) begin
      fails++;
      $display("FAIL backpressure_hold: data_o=%h valid_o=%b ready_o=%b required %h/1/0", data_o, valid_o, ready_o, exp);
    end
    handshake_out();
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: valid_o=%b ready_o=%b required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_last();
    bit ok;
    int cyc;
    logic [127:0] d = 128'h0123456789abcdef_0123456789abcdef;
    int exp_cyc = SKIP ? 0 : 4;
    accept_one(d, 1'b1, ok);
    wait_valid(cyc);
    tests++;
    if (!ok || cyc !== exp_cyc) begin
      fails++;
      $display("FAIL last_latency: cycles=%0d required %0d", cyc, exp_cyc);
    end
    tests++;
    if (data_o !== expected(d, 1'b1)) begin
      fails++;
      $display("FAIL last_data: got %h required %h", data_o, expected(d, 1'b1));
    end
    handshake_out();
    last_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    accept_one(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_busy: valid_o=%b ready_o=%b data_o=%h required 0/0/0", valid_o, ready_o, data_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (valid_o) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    ready_i = 1'b0;
    tests++;
    if (seen || ready_o !== 1'b1 || data_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_discard: valid_seen=%b ready_o=%b data_o=%h required 0/1/0", seen, ready_o, data_o);
    end
  endtask

  task automatic test_ignore_input();
    bit ok;
    bit rdy_seen = 1'b0;
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    accept_one(d, 1'b0, ok);
    valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_i = {$urandom, $urandom, $urandom, $urandom};
      if (ready_o) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok || rdy_seen || valid_o !== 1'b1 || data_o !== inv_mix_state(d)) begin
      fails++;
      $display("FAIL ignore_input: data_o=%h valid_o=%b ready_seen=%b required %h/1/0", data_o, valid_o, rdy_seen, inv_mix_state(d));
    end
    valid_i = 1'b0;
    handshake_out();
  endtask

  task automatic test_back_to_back();
    int n = 24;
    int got = 0;
    bit drv_done = 1'b0;
    bit mon_done = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bit ok;
          logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
          logic last = ($urandom_range(0, 3) == 0);
          accept_one(d, last, ok);
          if (ok) exp_q.push_back(expected(d, last));
          else begin
            tests++;
            fails++;
            $display("FAIL b2b_accept_timeout: item %0d not accepted", i);
          end
        end
        drv_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !(drv_done && exp_q.size() == 0); c++) begin
          @(negedge clk);
          if (valid_o && ready_i) begin
            logic [127:0] e;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL b2b_unexpected: got %h with nothing expected", data_o);
            end else begin
              e = exp_q.pop_front();
              if (data_o !== e) begin
                fails++;
                $display("FAIL b2b_data: item %0d got %h required %h", got, data_o, e);
              end
            end
            got++;
          end
        end
        mon_done = 1'b1;
      end
      begin
        while (!mon_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b0;
      end
    join
    tests++;
    if (got !== n || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL b2b_count: received %0d left %0d required %0d/0", got, exp_q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_known_vector(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                      128'hdb135345_f20a225c_01010101_d4d4d4d5, "vec027");
    test_backpressure();
    test_last();
    test_reset_mid();
    test_known_vector(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                      128'hdb135345_f20a225c_01010101_d4d4d4d5, "after_reset");
    test_ignore_input();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
